// File: rtl/y_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32 control sequencer: states,
// opcodes, ALU ops and the per-state strobe bundle.
package y_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LW  = 7'b0000011;
  localparam logic [6:0] OPC_SW  = 7'b0100011;
  localparam logic [6:0] OPC_BEQ = 7'b1100011;
  localparam logic [6:0] OPC_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic       pcwrite;
    logic       regwrite;
    logic       alusrc;
    logic [2:0] op;
    logic       memread;
    logic       memwrite;
    logic       mem2reg;
    logic       isbranch;
    logic       isjump;
    logic       intr;
  } ctrl_t;

  // Moore strobes for a given state and latched opcode; the SW completion
  // PCWrite depends on memReady and is added outside this function.
  function automatic ctrl_t ctrl_for(input state_t st, input logic [6:0] opc,
                                     input logic [2:0] aluop);
    ctrl_t c;
    logic  imm_src;
    c       = '0;
    imm_src = (opc == OPC_I) || (opc == OPC_LW) || (opc == OPC_SW);
    case (st)
      S_EXEC: begin
        c.alusrc   = imm_src;
        c.op       = aluop;
        c.isbranch = (opc == OPC_BEQ);
        c.isjump   = (opc == OPC_JAL);
        c.pcwrite  = (opc == OPC_BEQ) || (opc == OPC_JAL);
      end
      S_MEM: begin
        c.alusrc   = imm_src;
        c.op       = aluop;
        c.memread  = (opc == OPC_LW);
        c.memwrite = (opc == OPC_SW);
        c.mem2reg  = (opc == OPC_LW);
      end
      S_WB: begin
        c.alusrc   = imm_src;
        c.op       = aluop;
        c.mem2reg  = (opc == OPC_LW);
        c.regwrite = 1'b1;
        c.pcwrite  = 1'b1;
      end
      S_TRAP: begin
        c.intr    = 1'b1;
        c.pcwrite = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/y_alu_dec.sv
// ALU operation decode from opcode/funct3/funct7[5], flagging encodings the
// sequencer does not implement.
module y_alu_dec
  import y_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [2:0] op,
  output logic       illegal
);

  always_comb begin
    op      = ALU_AND;
    illegal = 1'b0;
    case (opcode)
      OPC_R, OPC_I: begin
        case (funct3)
          3'b000:  op = (opcode == OPC_R && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b111:  op = ALU_AND;
          3'b110:  op = ALU_OR;
          3'b010:  op = ALU_SLT;
          default: illegal = 1'b1;
        endcase
      end
      OPC_LW, OPC_SW, OPC_JAL: op = ALU_ADD;
      OPC_BEQ:                 op = ALU_SUB;
      default:                 illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/y_mc_ctrl.sv
// Multi-cycle control sequencer: latches the fetched instruction and steps
// FETCH/DECODE/EXEC/MEM/WB/TRAP, driving per-state strobes for the datapath.
//
//   state  | meaning
//   FETCH  | latch ins into IR
//   DECODE | check opcode/funct3; illegal goes to TRAP
//   EXEC   | ALU cycle; BEQ/JAL retire here
//   MEM    | data-memory access, held until memReady
//   WB     | register write, retire
//   TRAP   | raise INT, redirect PC, set sticky illegal
module y_mc_ctrl
  import y_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ins,
  input  logic        zero,
  input  logic        memReady,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        ALUSrc,
  output logic [2:0]  op,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        Mem2Reg,
  output logic        isbranch,
  output logic        isjump,
  output logic        INT,
  output logic        illegal,
  output logic [2:0]  state,
  output logic [31:0] instret
);

  state_t      st, nst;
  logic [31:0] ir;
  logic [6:0]  opc;
  logic [2:0]  aluop;
  logic        dec_ill;
  ctrl_t       ctrl_q;
  logic        illegal_q;
  logic [31:0] instret_q;
  logic        sw_done;
  logic        retire;
  logic        unused_bits;

  assign opc = ir[6:0];

  y_alu_dec u_alu_dec (
    .opcode   (opc),
    .funct3   (ir[14:12]),
    .funct7b5 (ir[30]),
    .op       (aluop),
    .illegal  (dec_ill)
  );

  // zero is consumed by yPC through isbranch; operand fields are yID's business.
  assign unused_bits = ^{zero, ir[31], ir[29:15], ir[11:7]};

  assign sw_done = (st == S_MEM) && (opc == OPC_SW) && memReady;
  assign retire  = (st == S_WB) || sw_done ||
                   ((st == S_EXEC) && ((opc == OPC_BEQ) || (opc == OPC_JAL)));

  always_comb begin
    nst = st;
    case (st)
      S_FETCH:  nst = S_DECODE;
      S_DECODE: nst = dec_ill ? S_TRAP : S_EXEC;
      S_EXEC: begin
        if (opc == OPC_R || opc == OPC_I)        nst = S_WB;
        else if (opc == OPC_LW || opc == OPC_SW) nst = S_MEM;
        else                                     nst = S_FETCH;
      end
      S_MEM: begin
        if (memReady) nst = (opc == OPC_LW) ? S_WB : S_FETCH;
      end
      default:  nst = S_FETCH;
    endcase
  end

  // Strobes are registered from the next state; IR only changes in FETCH,
  // whose successor (DECODE) drives nothing, so decoding the current IR is safe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= S_FETCH;
      ir        <= '0;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      st     <= nst;
      ctrl_q <= ctrl_for(nst, opc, aluop);
      if (st == S_FETCH) ir <= ins;
      if (nst == S_TRAP) illegal_q <= 1'b1;
      if (retire) instret_q <= instret_q + 32'd1;
    end
  end

  assign PCWrite  = ctrl_q.pcwrite | sw_done;
  assign RegWrite = ctrl_q.regwrite;
  assign ALUSrc   = ctrl_q.alusrc;
  assign op       = ctrl_q.op;
  assign MemRead  = ctrl_q.memread;
  assign MemWrite = ctrl_q.memwrite;
  assign Mem2Reg  = ctrl_q.mem2reg;
  assign isbranch = ctrl_q.isbranch;
  assign isjump   = ctrl_q.isjump;
  assign INT      = ctrl_q.intr;
  assign illegal  = illegal_q;
  assign state    = st;
  assign instret  = instret_q;

endmodule

// File: tb/tb_y_mc_ctrl.sv
// Directed bench for y_mc_ctrl: stimulus pushes hand-computed per-cycle
// expectations; a negedge monitor pops and compares them.
module tb_y_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ins;
  logic        zero;
  logic        memReady;
  logic        PCWrite, RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg;
  logic        isbranch, isjump, INT, illegal;
  logic [2:0]  op, state;
  logic [31:0] instret;

  typedef struct packed {
    logic [2:0]  st;
    logic        pcw, rw, asrc;
    logic [2:0]  op;
    logic        mr, mw, m2r, br, j, intr, ill;
    logic [31:0] cnt;
  } exp_t;

  exp_t        q[$];
  string       lq[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] ic     = 32'd0;
  logic        il     = 1'b0;
  exp_t        m_e, m_a;
  string       m_l;

  always #5 clk = ~clk;

  y_mc_ctrl dut (
    .clk(clk), .rst(rst), .ins(ins), .zero(zero), .memReady(memReady),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUSrc(ALUSrc), .op(op),
    .MemRead(MemRead), .MemWrite(MemWrite), .Mem2Reg(Mem2Reg),
    .isbranch(isbranch), .isjump(isjump), .INT(INT), .illegal(illegal),
    .state(state), .instret(instret)
  );

  always @(negedge clk) begin
    if (q.size() > 0) begin
      m_e = q.pop_front();
      m_l = lq.pop_front();
      m_a = {state, PCWrite, RegWrite, ALUSrc, op, MemRead, MemWrite, Mem2Reg,
             isbranch, isjump, INT, illegal, instret};
      n_chk++;
      if (m_a === m_e) n_pass++;
      else $display("FAIL %s: got st=%0d pcw/rw/asrc=%b%b%b op=%b mr/mw/m2r/br/j/int/ill=%b%b%b%b%b%b%b cnt=%h, required st=%0d pcw/rw/asrc=%b%b%b op=%b mr/mw/m2r/br/j/int/ill=%b%b%b%b%b%b%b cnt=%h",
                    m_l, m_a.st, m_a.pcw, m_a.rw, m_a.asrc, m_a.op, m_a.mr, m_a.mw, m_a.m2r,
                    m_a.br, m_a.j, m_a.intr, m_a.ill, m_a.cnt,
                    m_e.st, m_e.pcw, m_e.rw, m_e.asrc, m_e.op, m_e.mr, m_e.mw, m_e.m2r,
                    m_e.br, m_e.j, m_e.intr, m_e.ill, m_e.cnt);
    end
  end

  function automatic exp_t v(input logic [2:0] st, input logic pcw, input logic rw,
                             input logic asrc, input logic [2:0] o, input logic mr,
                             input logic mw, input logic m2r, input logic br,
                             input logic j, input logic it);
    exp_t e;
    e = {st, pcw, rw, asrc, o, mr, mw, m2r, br, j, it, il, ic};
    return e;
  endfunction

  task automatic cyc(input logic [31:0] i, input logic m, input string l, input exp_t e);
    ins      = i;
    memReady = m;
    q.push_back(e);
    lq.push_back(l);
    @(posedge clk);
    #1;
  endtask

  task automatic run_alu(input logic [31:0] i, input logic asrc, input logic [2:0] o,
                         input string n);
    cyc(i,     1'b1, {n, "_fetch"},  v(3'd0, 0, 0, 0,    3'b000, 0, 0, 0, 0, 0, 0));
    cyc(32'd0, 1'b1, {n, "_decode"}, v(3'd1, 0, 0, 0,    3'b000, 0, 0, 0, 0, 0, 0));
    cyc(32'd0, 1'b1, {n, "_exec"},   v(3'd2, 0, 0, asrc, o,      0, 0, 0, 0, 0, 0));
    cyc(32'd0, 1'b1, {n, "_wb"},     v(3'd4, 1, 1, asrc, o,      0, 0, 0, 0, 0, 0));
    ic++;
  endtask

  task automatic run_jb(input logic [31:0] i, input logic br, input logic j,
                        input logic [2:0] o, input string n);
    cyc(i,     1'b1, {n, "_fetch"},  v(3'd0, 0, 0, 0, 3'b000, 0, 0, 0, 0,  0, 0));
    cyc(32'd0, 1'b1, {n, "_decode"}, v(3'd1, 0, 0, 0, 3'b000, 0, 0, 0, 0,  0, 0));
    cyc(32'd0, 1'b1, {n, "_exec"},   v(3'd2, 1, 0, 0, o,      0, 0, 0, br, j, 0));
    ic++;
  endtask

  task automatic run_trap(input logic [31:0] i, input string n);
    cyc(i,     1'b1, {n, "_fetch"},  v(3'd0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0));
    cyc(32'd0, 1'b1, {n, "_decode"}, v(3'd1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0));
    il = 1'b1;
    cyc(32'd0, 1'b1, {n, "_trap"},   v(3'd5, 1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 1));
  endtask

  task automatic run_lw(input logic [31:0] i, input int waits, input string n);
    cyc(i,     1'b1, {n, "_fetch"},  v(3'd0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0));
    cyc(32'd0, 1'b1, {n, "_decode"}, v(3'd1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0));
    cyc(32'd0, 1'b1, {n, "_exec"},   v(3'd2, 0, 0, 1, 3'b010, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < waits; k++)
      cyc(32'd0, 1'b0, {n, "_memwait"}, v(3'd3, 0, 0, 1, 3'b010, 1, 0, 1, 0, 0, 0));
    cyc(32'd0, 1'b1, {n, "_memdone"}, v(3'd3, 0, 0, 1, 3'b010, 1, 0, 1, 0, 0, 0));
    cyc(32'd0, 1'b1, {n, "_wb"},      v(3'd4, 1, 1, 1, 3'b010, 0, 0, 1, 0, 0, 0));
    ic++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; ins = 32'd0; zero = 1'b0; memReady = 1'b0;
    @(posedge clk); #1;
    cyc(32'd0, 1'b0, "reset_hold", v(3'd0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;

    run_alu(32'h002081B3, 1'b0, 3'b010, "add");
    run_lw (32'h0000A103, 3, "lw");
    zero = 1'b1;
    run_jb (32'h00208463, 1'b1, 1'b0, 3'b110, "beq");
    zero = 1'b0;
    run_jb (32'h0000006F, 1'b0, 1'b1, 3'b010, "jal");
    run_alu(32'h40208133, 1'b0, 3'b110, "sub");
    run_alu(32'h0020E133, 1'b0, 3'b001, "or");
    run_alu(32'h0020A133, 1'b0, 3'b111, "slt");
    run_alu(32'h0000F093, 1'b1, 3'b000, "andi");
    run_alu(32'h40008093, 1'b1, 3'b010, "addi_b30");
    run_trap(32'h0000007F, "trap_opc");
    run_trap(32'h00209133, "trap_f3");

    // SW with memReady already high on MEM entry
    cyc(32'h0020A023, 1'b1, "sw_fetch",  v(3'd0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0));
    cyc(32'd0,        1'b1, "sw_decode", v(3'd1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0));
    cyc(32'd0,        1'b1, "sw_exec",   v(3'd2, 0, 0, 1, 3'b010, 0, 0, 0, 0, 0, 0));
    cyc(32'd0,        1'b1, "sw_mem",    v(3'd3, 1, 0, 1, 3'b010, 0, 1, 0, 0, 0, 0));
    ic++;

    // reset pulsed while SW waits in MEM
    cyc(32'h0020A023, 1'b0, "swr_fetch",  v(3'd0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0));
    cyc(32'd0,        1'b0, "swr_decode", v(3'd1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0));
    cyc(32'd0,        1'b0, "swr_exec",   v(3'd2, 0, 0, 1, 3'b010, 0, 0, 0, 0, 0, 0));
    cyc(32'd0,        1'b0, "swr_mem",    v(3'd3, 0, 0, 1, 3'b010, 0, 1, 0, 0, 0, 0));
    rst = 1'b1; ic = 32'd0; il = 1'b0;
    cyc(32'd0,        1'b1, "swr_reset",  v(3'd0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    run_alu(32'h002081B3, 1'b0, 3'b010, "add_after_rst");

    // instret wrap
    force dut.instret_q = 32'hFFFFFFFF;
    #1;
    release dut.instret_q;
    ic = 32'hFFFFFFFF;
    run_jb(32'h00208463, 1'b1, 1'b0, 3'b110, "beq_wrap");
    cyc(32'd0, 1'b1, "wrap_fetch", v(3'd0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0));

    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_chk++;
      $display("FAIL drain: got %0d pending entries, required 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
